// File: rtl/conv_pkg.sv
// Shared state encoding and sizing helpers for the convolution sequencer.
package conv_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_MAC,
      ST_DRAIN,
      ST_OUT,
      ST_DONE
   } conv_state_e;

   function automatic int unsigned conv_num_outputs(input int unsigned x_size,
                                                    input int unsigned f_size);
      return x_size - f_size + 1;
   endfunction

endpackage

// File: rtl/conv_tap_counter.sv
// Loadable, enabled up-counter that saturates at MAX_VAL and flags it.
module conv_tap_counter #(
   parameter int unsigned WIDTH   = 2,
   parameter int unsigned MAX_VAL = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] cnt_o,
   output logic             tc_o
);

   localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   assign tc_o  = (cnt_q == MAX_CNT);
   assign cnt_o = cnt_q;

   // NOTE: default assignment first so every path assigns cnt_d and no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && !tc_o) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments and an asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Control sequencer for a 1-D valid convolution: walks output indices and filter taps.
module conv_seq_ctrl
   import conv_pkg::*;
#(
   parameter int unsigned X_SIZE           = 8,
   parameter int unsigned F_SIZE           = 4,
   parameter int unsigned X_MEM_ADDR_WIDTH = $clog2(X_SIZE),
   parameter int unsigned F_MEM_ADDR_WIDTH = $clog2(F_SIZE)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        conv_start,
   input  logic                        m_ready_y,
   output logic                        load_xaddr,
   output logic [X_MEM_ADDR_WIDTH-1:0] load_xaddr_val,
   output logic                        en_xaddr_incr,
   output logic                        load_faddr,
   output logic                        en_faddr_incr,
   output logic                        reset_accum,
   output logic                        en_accum,
   output logic                        m_valid_y,
   output logic                        conv_done,
   output logic                        busy
);

   localparam int unsigned LAST_IDX = conv_num_outputs(X_SIZE, F_SIZE) - 1;

   conv_state_e                 state_q;
   logic [F_MEM_ADDR_WIDTH-1:0] k_q;
   logic                        k_tc;
   logic [X_MEM_ADDR_WIDTH-1:0] out_idx_q;
   logic                        idx_tc;
   logic                        out_hs;

   assign out_hs = (state_q == ST_OUT) && m_ready_y;

   // Tap counter: cleared in LOAD, steps once per MAC cycle, flags the last tap.
   conv_tap_counter #(
      .WIDTH   (F_MEM_ADDR_WIDTH),
      .MAX_VAL (F_SIZE - 1)
   ) u_k_cnt (
      .clk        (clk),
      .rst_n      (reset),
      .load_i     (state_q == ST_LOAD),
      .load_val_i ('0),
      .en_i       (state_q == ST_MAC),
      .cnt_o      (k_q),
      .tc_o       (k_tc)
   );

   conv_tap_counter #(
      .WIDTH   (X_MEM_ADDR_WIDTH),
      .MAX_VAL (LAST_IDX)
   ) u_idx_cnt (
      .clk        (clk),
      .rst_n      (reset),
      .load_i     ((state_q == ST_IDLE) && conv_start),
      .load_val_i ('0),
      .en_i       (out_hs),
      .cnt_o      (out_idx_q),
      .tc_o       (idx_tc)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE:  if (conv_start) state_q <= ST_LOAD;
            ST_LOAD:  state_q <= ST_MAC;
            ST_MAC:   if (k_tc) state_q <= ST_DRAIN;
            ST_DRAIN: state_q <= ST_OUT;
            ST_OUT:   if (m_ready_y) state_q <= idx_tc ? ST_DONE : ST_LOAD;
            ST_DONE:  state_q <= ST_IDLE;
            default:  state_q <= ST_IDLE;
         endcase
      end
   end

   // Outputs decode registered state only; the last product lands during DRAIN.
   assign load_xaddr     = (state_q == ST_LOAD);
   assign load_faddr     = (state_q == ST_LOAD);
   assign reset_accum    = (state_q == ST_LOAD);
   assign load_xaddr_val = out_idx_q;
   assign en_xaddr_incr  = (state_q == ST_MAC) && !k_tc;
   assign en_faddr_incr  = (state_q == ST_MAC) && !k_tc;
   assign en_accum       = ((state_q == ST_MAC) && (k_q != '0)) || (state_q == ST_DRAIN);
   assign m_valid_y      = (state_q == ST_OUT);
   assign conv_done      = (state_q == ST_DONE);
   assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Self-checking bench: timeline reference model plus a small x/f/accumulator datapath.
module tb_conv_seq_ctrl;

   localparam int X_SIZE = 8;
   localparam int F_SIZE = 4;
   localparam int XW     = $clog2(X_SIZE);
   localparam int FW     = $clog2(F_SIZE);
   localparam int N_OUT  = X_SIZE - F_SIZE + 1;

   logic          clk        = 1'b0;
   logic          reset      = 1'b0;
   logic          conv_start = 1'b0;
   logic          m_ready_y  = 1'b0;
   logic          load_xaddr;
   logic [XW-1:0] load_xaddr_val;
   logic          en_xaddr_incr;
   logic          load_faddr;
   logic          en_faddr_incr;
   logic          reset_accum;
   logic          en_accum;
   logic          m_valid_y;
   logic          conv_done;
   logic          busy;

   always #5 clk = ~clk;

   conv_seq_ctrl #(
      .X_SIZE (X_SIZE),
      .F_SIZE (F_SIZE)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .conv_start     (conv_start),
      .m_ready_y      (m_ready_y),
      .load_xaddr     (load_xaddr),
      .load_xaddr_val (load_xaddr_val),
      .en_xaddr_incr  (en_xaddr_incr),
      .load_faddr     (load_faddr),
      .en_faddr_incr  (en_faddr_incr),
      .reset_accum    (reset_accum),
      .en_accum       (en_accum),
      .m_valid_y      (m_valid_y),
      .conv_done      (conv_done),
      .busy           (busy)
   );

   // Datapath driven by the controller: registered address counters, 1-cycle memory reads.
   int            xmem [X_SIZE];
   int            fmem [F_SIZE];
   logic [XW-1:0] xaddr = '0;
   logic [FW-1:0] faddr = '0;
   int            xrd   = 0;
   int            frd   = 0;
   int            accum = 0;

   always @(posedge clk) begin
      xrd <= xmem[xaddr];
      frd <= fmem[faddr];
      if (load_xaddr)         xaddr <= load_xaddr_val;
      else if (en_xaddr_incr) xaddr <= xaddr + XW'(1);
      if (load_faddr)         faddr <= '0;
      else if (en_faddr_incr) faddr <= faddr + FW'(1);
      if (reset_accum)        accum <= 0;
      else if (en_accum)      accum <= accum + xrd * frd;
   end

   // Reference model: position on a timeline measured from each LOAD cycle.
   // t=0 LOAD, t=1..F MAC taps, t=F+1 drain, t>=F+2 waiting for the handshake.
   bit m_busy = 1'b0;
   bit m_done = 1'b0;
   int m_t    = 0;
   int m_idx  = 0;

   int n_checks = 0;
   int n_fail   = 0;
   int cycle    = 0;
   int done_cnt = 0;
   int hs_idx[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cycle);
      end
   endtask

   function automatic int ref_y(input int idx);
      int s;
      s = 0;
      for (int k = 0; k < F_SIZE; k++) s += xmem[idx + k] * fmem[k];
      return s;
   endfunction

   function automatic logic [8:0] exp_ctrl();
      logic run, ld, inc, acc, vld;
      run = m_busy && !m_done;
      ld  = run && (m_t == 0);
      inc = run && (m_t >= 1) && (m_t < F_SIZE);
      acc = run && (m_t >= 2) && (m_t <= F_SIZE + 1);
      vld = run && (m_t >= F_SIZE + 2);
      return {ld, inc, ld, inc, ld, acc, vld, m_done, m_busy};
   endfunction

   function automatic logic [8:0] dut_ctrl();
      return {load_xaddr, en_xaddr_incr, load_faddr, en_faddr_incr, reset_accum,
              en_accum, m_valid_y, conv_done, busy};
   endfunction

   task automatic model_advance(input bit cs, input bit rdy);
      if (!reset) begin
         m_busy = 0; m_done = 0; m_t = 0; m_idx = 0;
      end else if (!m_busy) begin
         if (cs) begin m_busy = 1; m_t = 0; m_idx = 0; end
      end else if (m_done) begin
         m_done = 0; m_busy = 0;
      end else if (m_t >= F_SIZE + 2) begin
         if (rdy) begin
            if (m_idx == X_SIZE - F_SIZE) m_done = 1;
            else begin m_idx++; m_t = 0; end
         end
      end else begin
         m_t++;
      end
   endtask

   // One clock: apply inputs, score any handshake, advance model, check outputs after the edge.
   task automatic step(input bit cs, input bit rdy);
      conv_start = cs;
      m_ready_y  = rdy;
      if (reset && m_valid_y && rdy) begin
         hs_idx.push_back(int'(load_xaddr_val));
         check("y", 32'(accum), 32'(ref_y(m_idx)));
      end
      @(posedge clk);
      model_advance(cs, rdy);
      #1;
      cycle++;
      check("ctrl", 32'(dut_ctrl()), 32'(exp_ctrl()));
      check("xaddr_val", 32'(load_xaddr_val), 32'(m_idx));
      if (conv_done) done_cnt++;
   endtask

   task automatic run_to_done(input bit rand_cs, input bit rand_rdy);
      int start_done;
      start_done = done_cnt;
      for (int c = 0; c < 400 && done_cnt == start_done; c++)
         step(rand_cs ? 1'($urandom_range(0, 1)) : 1'b0,
              rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      check("conv_end", 32'(done_cnt - start_done), 32'd1);
   endtask

   initial begin
      int first_valid;
      int y_hold;

      for (int i = 0; i < X_SIZE; i++) xmem[i] = i + 1;
      for (int i = 0; i < F_SIZE; i++) fmem[i] = 1;

      // Reset held with conv_start high: nothing may move.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
      check("rst_busy", 32'(busy), 32'd0);
      reset = 1'b1;

      // Streaming run: conv_start and m_ready_y held high.
      first_valid = -1;
      hs_idx.delete();
      done_cnt = 0;
      for (int c = 0; c < 60 && done_cnt == 0; c++) begin
         step(1'b1, 1'b1);
         if (m_valid_y && first_valid < 0) first_valid = c;
      end
      check("first_valid", 32'(first_valid), 32'd6);
      check("n_outputs", 32'(hs_idx.size()), 32'(N_OUT));
      for (int i = 0; i < N_OUT && i < hs_idx.size(); i++)
         check("hs_idx", 32'(hs_idx[i]), 32'(i));
      check("done_cnt", 32'(done_cnt), 32'd1);
      step(1'b1, 1'b1);
      check("idle_gap", 32'(busy), 32'd0);
      step(1'b1, 1'b1);
      check("restart_load", 32'(load_xaddr), 32'd1);

      // Backpressure: hold m_ready_y low for three OUT cycles.
      for (int c = 0; c < 40 && !m_valid_y; c++) step(1'($urandom_range(0, 1)), 1'b1);
      check("bp_reach", 32'(m_valid_y), 32'd1);
      y_hold = accum;
      for (int i = 0; i < 3; i++) begin
         step(1'($urandom_range(0, 1)), 1'b0);
         check("bp_valid", 32'(m_valid_y), 32'd1);
         check("bp_accum_en", 32'(en_accum), 32'd0);
         check("bp_y", 32'(accum), 32'(y_hold));
      end
      run_to_done(1'b1, 1'b1);
      step(1'b0, 1'b0);

      // Random data, random ready and conv_start toggling while busy.
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < X_SIZE; i++) xmem[i] = int'($urandom_range(0, 15));
         for (int i = 0; i < F_SIZE; i++) fmem[i] = int'($urandom_range(0, 15));
         step(1'b1, 1'($urandom_range(0, 1)));
         run_to_done(1'b1, 1'b1);
         step(1'b0, 1'b0);
      end

      // Asynchronous reset in MAC tap k=2.
      step(1'b1, 1'b1);
      for (int c = 0; c < 20 && m_t != 3; c++) step(1'($urandom_range(0, 1)), 1'b1);
      check("k2_accum", 32'(en_accum), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("rst_async_ctrl", 32'(dut_ctrl()), 32'd0);
      check("rst_async_val", 32'(load_xaddr_val), 32'd0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      reset = 1'b1;
      hs_idx.delete();
      step(1'b1, 1'b1);
      check("post_rst_load", 32'(load_xaddr), 32'd1);
      run_to_done(1'b0, 1'b1);
      check("post_rst_first_idx", 32'(hs_idx.size() > 0 ? hs_idx[0] : -1), 32'd0);
      step(1'b0, 1'b0);
      check("final_idle", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/conv_seq_ctrl.md
CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 SHALL have parameter X_SIZE, default 8: x vector length.
REQ-002 SHALL have parameter F_SIZE, default 4: filter length; legal range is 2 <= F_SIZE <= X_SIZE.
REQ-003 SHALL have parameter X_MEM_ADDR_WIDTH, default $clog2(X_SIZE): x address width.
REQ-004 SHALL have parameter F_MEM_ADDR_WIDTH, default $clog2(F_SIZE): f address width.
REQ-005 SHALL have ports: clk  in  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have ports: reset  in  1  asynchronous, active-low (0 = reset asserted).
REQ-007 SHALL have ports: conv_start  in  1  x and f memories both full.
REQ-008 SHALL have ports: m_ready_y  in  1  downstream ready for y.
REQ-009 SHALL have ports: load_xaddr  out  1  load x address with load_xaddr_val.
REQ-010 SHALL have ports: load_xaddr_val  out  X_MEM_ADDR_WIDTH  current output index.
REQ-011 SHALL have ports: en_xaddr_incr  out  1  increment x address.
REQ-012 SHALL have ports: load_faddr  out  1  load f address with 0.
REQ-013 SHALL have ports: en_faddr_incr  out  1  increment f address.
REQ-014 SHALL have ports: reset_accum  out  1  clear accumulator.
REQ-015 SHALL have ports: en_accum  out  1  accumulate current product.
REQ-016 SHALL have ports: m_valid_y  out  1  y result valid.
REQ-017 SHALL have ports: conv_done  out  1  one-cycle end-of-convolution pulse.
REQ-018 SHALL have ports: busy  out  1  FSM not in IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, MAC, DRAIN, OUT, DONE.
REQ-020 IDLE SHALL go to LOAD when conv_start=1 and clear out_idx to 0; otherwise it SHALL stay in IDLE.
REQ-021 LOAD SHALL last one cycle: load_xaddr=1, load_faddr=1, reset_accum=1; next state MAC with tap counter k=0.
REQ-022 MAC SHALL last F_SIZE cycles, k=0..F_SIZE-1, with memory addresses x[out_idx+k] and f[k] valid during cycle k.
REQ-023 In MAC, en_xaddr_incr and en_faddr_incr SHALL both be 1 for k<F_SIZE-1 and 0 at k=F_SIZE-1.
REQ-024 Memory read latency is one cycle; en_accum SHALL be 1 in MAC cycles k>=1 and in DRAIN, giving exactly F_SIZE accumulations per output.
REQ-025 DRAIN SHALL last one cycle, then go to OUT.
REQ-026 OUT SHALL hold m_valid_y=1 until m_ready_y=1, with en_accum=0 and reset_accum=0 so the accumulator stays frozen under backpressure.
REQ-027 On an OUT handshake with out_idx<X_SIZE-F_SIZE, the block SHALL increment out_idx and go to LOAD.
REQ-028 On an OUT handshake with out_idx=X_SIZE-F_SIZE, the block SHALL go to DONE.
REQ-029 DONE SHALL last one cycle with conv_done=1, then go to IDLE; conv_start is not sampled in DONE.
REQ-030 Latency SHALL be F_SIZE+2 cycles from conv_start sampled in IDLE to first m_valid_y=1; each later output SHALL take F_SIZE+2 cycles after the previous handshake.
REQ-031 X_SIZE-F_SIZE+1 outputs SHALL be produced per convolution.
REQ-032 load_xaddr_val SHALL equal out_idx at all times.
REQ-033 conv_start changes outside IDLE SHALL be ignored.
REQ-034 m_ready_y SHALL be ignored outside OUT.
REQ-035 All control outputs SHALL be 0 in every state and cycle not listed above.
REQ-036 busy SHALL be 1 in every state except IDLE.

Reset
REQ-037 While reset=0, the block SHALL immediately enter IDLE, clear out_idx and k to 0, and drive every output to 0, including mid-MAC and mid-OUT.
REQ-038 After reset is released, the first state change SHALL occur on the following rising clk with conv_start=1.

Structure
REQ-039 The state enum typedef and a function computing the output count (X_SIZE-F_SIZE+1) SHALL reside in shared package conv_pkg.
REQ-040 Counters k and out_idx SHALL be sized to their parameter ranges with no wrap; arithmetic is unsigned.
REQ-041 One sub-module, conv_tap_counter, SHALL be used: a loadable, enabled counter with terminal-count flag, instantiated for k and for out_idx.
REQ-042 All outputs SHALL be decoded from registered state and counters only, with no combinational path from m_ready_y or conv_start to any output.

Verification (X_SIZE=8, F_SIZE=4)
REQ-043 conv_start=1 held, m_ready_y=1 -> m_valid_y first at cycle 6, five outputs, load_xaddr_val sequence 0,1,2,3,4, then a single conv_done pulse.
REQ-044 x=1..8, f=1,1,1,1 through the full datapath -> y = 10,14,18,22,26.
REQ-045 m_ready_y=0 for 3 cycles in OUT -> m_valid_y held, en_accum=0 throughout, and y unchanged.
REQ-046 reset=0 asserted at MAC k=2 -> all outputs 0 at once; after release with conv_start=1, the sequence restarts with out_idx=0.
REQ-047 conv_start held 1 through DONE -> exactly one IDLE cycle, then a new LOAD.
REQ-048 conv_start toggled during MAC and OUT -> no change in sequence timing.
